ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the byte-wide data RAM between two requesters.
  - Port 0: the CPU memory path (fetch and load/store).
  - Port 1: a loader/debug master.
- Each requester issues one byte, halfword or word access. The block serializes it into 1–4 little-endian byte cycles on the RAM, then reassembles read data with sign or zero extension.
- The CPU control sequencer no longer steps the RAM byte lanes itself. It raises a request and waits for the acknowledge.

Parameters:
- ADDR_W, 16, RAM address width. Request addresses are truncated to the low ADDR_W bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk)
- req0  in  1  port 0 request
- we0  in  1  port 0 write (1) / read (0)
- size0  in  2  port 0 size: 0 byte, 1 half, 2 or 3 word
- uns0  in  1  port 0 zero-extend read data
- addr0  in  32  port 0 byte address
- wdata0  in  32  port 0 write data, byte k in bits [8k+7:8k]
- req1, we1, size1, uns1, addr1, wdata1  in  1/1/2/1/32/32  port 1, same meaning as port 0
- ack0  out  1  one-cycle completion pulse for port 0
- ack1  out  1  one-cycle completion pulse for port 1
- rdata  out  32  extended read data; valid only in a read ack cycle
- busy  out  1  a transaction is in progress (state != IDLE)
- ram_addr  out  ADDR_W  RAM byte address
- ram_we  out  1  RAM write enable for the current cycle
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte; synchronous, valid in the cycle after its address was presented

Behaviour:
- FSM states: IDLE, XFER, WAIT, ACK. N = number of bytes (1, 2, or 4 for size 0, 1, 2/3).
- IDLE:
  - req0/req1 are sampled only in this state.
  - If either is high: select a winner, latch its we/size/uns/addr/wdata and port id, set cnt=0, go to XFER.
- Arbitration: round-robin over a last_grant register, initialized to 1 at reset so port 0 wins the first tie.
  - Both requests high: grant the port that was not last granted.
  - One request high: grant it. last_grant updates on every grant.
- XFER, one cycle per byte:
  - ram_addr = latched_addr + cnt, truncated to ADDR_W bits; wraps modulo 2^ADDR_W.
  - ram_we = latched_we.
  - ram_wdata = latched_wdata[8cnt+7:8cnt].
  - For a read, ram_rdata from byte cnt-1 is captured into lane cnt-1 (when cnt > 0).
  - cnt increments. When cnt == N-1: write goes to ACK, read goes to WAIT.
- WAIT (reads only): ram_we=0; capture the final byte into lane N-1; go to ACK.
- ACK:
  - Pulse ack0 or ack1 for the latched port for one cycle; go to IDLE.
  - On a read, rdata = assembled value extended from bit 7 (byte) or bit 15 (half), signed unless uns. Word is passed unchanged.
  - On a write, rdata = 0.
- Latency from the IDLE grant cycle T:
  - write: ack at T+N+1 (word write: T+5)
  - read: ack at T+N+2 (word read: T+6)
- Outside XFER: ram_we=0, ram_wdata=0, ram_addr=0. Unused lanes of rdata are 0 before extension.
- No alignment check. Misaligned accesses are legal and simply wrap within the RAM.
- Request contract:
  - The requester holds req high until its ack.
  - It must drop req on the clock edge at which it samples ack, unless it wants a back-to-back request.
  - A req still high in the following IDLE cycle starts a new transaction.
  - Address/data inputs need to be stable only in the grant cycle.
- A request that rises during busy waits. The loser of a tie waits at most one transaction.
- Reset mid-transaction: all state cleared on that edge. No ack issued; a partial write already performed remains in RAM. Then ram_we=0.
- Reset values: ack0=0, ack1=0, rdata=0, busy=0, ram_we=0, ram_addr=0, ram_wdata=0, state=IDLE, cnt=0, last_grant=1.

Test Plan:
- Word write: port0 writes 0xDEADBEEF to addr 0x0010. Required: ram_addr 0x10..0x13 with ram_wdata EF, BE, AD, DE on 4 consecutive cycles with ram_we=1; ack0 at T+5; rdata=0.
- Signed/unsigned reads: RAM[0x20]=0x80. Byte read with uns=0 → rdata 0xFFFFFF80 at T+3. Byte read with uns=1 → 0x00000080. Halfword read of 0x21..0x22 = {0x7F, 0x80} with uns=0 → 0xFFFF807F at T+4.
- Arbitration: req0 and req1 rise in the same cycle after reset → port0 granted first; port1 granted in the IDLE after ack0 with req0 still high; then port0 again. Exactly one ack per transaction.
- Address wrap: ADDR_W=16, word write at 0xFFFE → bytes written to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-write: assert reset after the 2nd XFER cycle of a word write. Required: next cycle busy=0 and ram_we=0; no ack; only the first two bytes were written; the next request gets port0 priority.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the byte-wide data RAM between two requesters.
//   Port 0 is the CPU memory path and port 1 is a loader/debug master.
//   Each granted access (byte/half/word) is serialized into 1..4
//   little-endian byte cycles on the RAM. Read bytes are reassembled
//   and then sign- or zero-extended.
//
// Ports:
//   clk, reset             clock; synchronous active-low reset
//   req/we/size/uns/addr/wdata {0,1}  per-port request fields
//   ack0, ack1             one-cycle completion pulse per port
//   rdata                  extended read data (valid in a read ack cycle)
//   busy                   transaction in progress
//   ram_addr/ram_we/ram_wdata  RAM byte interface (registered)
//   ram_rdata              RAM read byte, one cycle after its address
module ram_arbiter #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [1:0]        size0,
   input  logic              uns0,
   input  logic [31:0]       addr0,
   input  logic [31:0]       wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [1:0]        size1,
   input  logic              uns1,
   input  logic [31:0]       addr1,
   input  logic [31:0]       wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [1:0] {IDLE, XFER, WAIT, ACK} state_t;

   state_t            state;
   logic [1:0]        cnt;
   logic              last_grant;
   logic              port;
   logic              l_we;
   logic              l_uns;
   logic [1:0]        l_size;
   logic [ADDR_W-1:0] l_addr;
   logic [31:0]       l_wdata;
   logic [31:0]       rbuf;

   // Index of the final byte: 0, 1 or 3.
   function automatic logic [1:0] last_of(input logic [1:0] s);
      case (s)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v,
                                          input logic [1:0] s,
                                          input logic u);
      case (s)
         2'd0:    return u ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
         2'd1:    return u ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
         default: return v;
      endcase
   endfunction

   // Round-robin: on a tie, the port not granted last time wins.
   logic        g_port;
   logic        g_we;
   logic        g_uns;
   logic [1:0]  g_size;
   logic [31:0] g_addr;
   logic [31:0] g_wdata;

   always_comb begin
      g_port = (req0 && req1) ? ~last_grant : req1;
      if (g_port) begin
         g_we = we1; g_size = size1; g_uns = uns1; g_addr = addr1; g_wdata = wdata1;
      end else begin
         g_we = we0; g_size = size0; g_uns = uns0; g_addr = addr0; g_wdata = wdata0;
      end
   end

   logic [1:0]  last_idx;
   logic [1:0]  nxt_cnt;
   logic [31:0] rfinal;

   always_comb begin
      last_idx = last_of(l_size);
      nxt_cnt  = cnt + 2'd1;
      // Final read byte arrives during WAIT; merge it before extending.
      rfinal   = rbuf;
      rfinal[{last_idx, 3'b000} +: 8] = ram_rdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         last_grant <= 1'b1;
         port       <= 1'b0;
         l_we       <= 1'b0;
         l_uns      <= 1'b0;
         l_size     <= 2'd0;
         l_addr     <= '0;
         l_wdata    <= 32'd0;
         rbuf       <= 32'd0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata      <= 32'd0;
         busy       <= 1'b0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_wdata  <= 8'd0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state      <= XFER;
                  busy       <= 1'b1;
                  cnt        <= 2'd0;
                  last_grant <= g_port;
                  port       <= g_port;
                  l_we       <= g_we;
                  l_uns      <= g_uns;
                  l_size     <= g_size;
                  l_addr     <= g_addr[ADDR_W-1:0];
                  l_wdata    <= g_wdata;
                  rbuf       <= 32'd0;
                  // RAM outputs are registered, so byte 0 is set up here.
                  ram_addr   <= g_addr[ADDR_W-1:0];
                  ram_we     <= g_we;
                  ram_wdata  <= g_wdata[7:0];
               end
            end
            XFER: begin
               if (!l_we && cnt != 2'd0)
                  rbuf[{cnt - 2'd1, 3'b000} +: 8] <= ram_rdata;
               if (cnt == last_idx) begin
                  ram_addr  <= '0;
                  ram_we    <= 1'b0;
                  ram_wdata <= 8'd0;
                  if (l_we) begin
                     state <= ACK;
                     ack0  <= ~port;
                     ack1  <= port;
                     rdata <= 32'd0;
                  end else begin
                     state <= WAIT;
                  end
               end else begin
                  cnt       <= nxt_cnt;
                  ram_addr  <= l_addr + ADDR_W'(nxt_cnt);
                  ram_wdata <= l_wdata[{nxt_cnt, 3'b000} +: 8];
               end
            end
            WAIT: begin
               state <= ACK;
               rbuf  <= rfinal;
               ack0  <= ~port;
               ack1  <= port;
               rdata <= extend(rfinal, l_size, l_uns);
            end
            ACK: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= 2'd0;
               rdata <= 32'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous byte RAM.
module tb_ram_arbiter;

   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0, we0, uns0, req1, we1, uns1;
   logic [1:0]        size0, size1;
   logic [31:0]       addr0, wdata0, addr1, wdata1;
   logic              ack0, ack1, busy, ram_we;
   logic [31:0]       rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata, ram_rdata;

   logic [7:0] mem [0:65535];

   int checks = 0;
   int errors = 0;
   int n_ack0 = 0;
   int n_ack1 = 0;

   ram_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .size0(size0), .uns0(uns0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .size1(size1), .uns1(uns1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set0(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
      req0 = 1'b1; we0 = we; size0 = sz; uns0 = u; addr0 = a; wdata0 = d;
   endtask

   task automatic set1(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
      req1 = 1'b1; we1 = we; size1 = sz; uns1 = u; addr1 = a; wdata1 = d;
   endtask

   // Steps until an ack appears (max 20 edges); returns edges taken.
   task automatic wait_ack(output logic a0, output logic a1, output int cyc);
      cyc = 0; a0 = 1'b0; a1 = 1'b0;
      while (cyc < 20 && !(a0 || a1)) begin
         step(); cyc++;
         a0 = ack0; a1 = ack1;
      end
   endtask

   logic [15:0] exp_a [4];
   logic [7:0]  exp_d [4];
   logic        a0, a1;
   int          cyc;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0020] = 8'h80;
      mem[16'h0021] = 8'h7F;
      mem[16'h0022] = 8'h80;
      reset = 1'b0;
      req0 = 0; we0 = 0; size0 = 0; uns0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; size1 = 0; uns1 = 0; addr1 = 0; wdata1 = 0;
      step(); step();

      // Reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ram", {7'd0, ram_we, ram_wdata, ram_addr}, 32'd0);
      reset = 1'b1;
      step();

      // Word write 0xDEADBEEF @0x10
      set0(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
      exp_d[0] = 8'hEF; exp_d[1] = 8'hBE; exp_d[2] = 8'hAD; exp_d[3] = 8'hDE;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("ww_addr%0d", k), 32'(ram_addr), 32'h10 + k);
         chk($sformatf("ww_we%0d", k), 32'(ram_we), 32'd1);
         chk($sformatf("ww_data%0d", k), 32'(ram_wdata), 32'(exp_d[k]));
         chk($sformatf("ww_noack%0d", k), 32'(ack0), 32'd0);
      end
      step();
      chk("ww_ack0", {30'd0, ack1, ack0}, 32'd1);
      chk("ww_rdata", rdata, 32'd0);
      chk("ww_ram_idle", {7'd0, ram_we, ram_wdata, ram_addr}, 32'd0);
      req0 = 1'b0;
      step();
      chk("ww_done", {30'd0, busy, ack0}, 32'd0);
      chk("ww_mem", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEAD_BEEF);

      // Signed byte read: ack at T+3
      set0(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
      step(); step();
      chk("rb_noack", 32'(ack0), 32'd0);
      step();
      chk("rb_ack", 32'(ack0), 32'd1);
      chk("rb_sext", rdata, 32'hFFFF_FF80);
      req0 = 1'b0;
      step();

      // Unsigned byte read
      set0(1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
      step(); step(); step();
      chk("rbu_ack", 32'(ack0), 32'd1);
      chk("rbu_zext", rdata, 32'h0000_0080);
      req0 = 1'b0;
      step();

      // Signed half read @0x21: ack at T+4
      set0(1'b0, 2'd1, 1'b0, 32'h21, 32'h0);
      step(); step(); step();
      chk("rh_noack", 32'(ack0), 32'd0);
      step();
      chk("rh_ack", 32'(ack0), 32'd1);
      chk("rh_sext", rdata, 32'hFFFF_807F);
      req0 = 1'b0;
      step();
      chk("rh_cleared", rdata, 32'd0);

      // Arbitration after a fresh reset
      reset = 1'b0;
      step();
      reset = 1'b1;
      set0(1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344);
      set1(1'b1, 2'd0, 1'b0, 32'h50, 32'h0000_00A5);
      wait_ack(a0, a1, cyc);
      chk("arb1_port", {30'd0, a1, a0}, 32'd1);
      chk("arb1_lat", 32'(cyc), 32'd5);
      wait_ack(a0, a1, cyc);
      chk("arb2_port", {30'd0, a1, a0}, 32'd2);
      chk("arb2_lat", 32'(cyc), 32'd3);
      req1 = 1'b0;
      wait_ack(a0, a1, cyc);
      chk("arb3_port", {30'd0, a1, a0}, 32'd1);
      chk("arb3_lat", 32'(cyc), 32'd6);
      req0 = 1'b0;
      step();
      chk("arb_mem0", {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]}, 32'h1122_3344);
      chk("arb_mem1", 32'(mem[16'h50]), 32'hA5);

      // Address wrap at 0xFFFE
      set0(1'b1, 2'd3, 1'b0, 32'h0001_FFFE, 32'h0A0B_0C0D);
      exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("wrap_addr%0d", k), 32'(ram_addr), 32'(exp_a[k]));
      end
      step();
      chk("wrap_ack", 32'(ack0), 32'd1);
      req0 = 1'b0;
      step();
      chk("wrap_mem", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]}, 32'h0A0B_0C0D);

      // Reset after the second XFER cycle of a word write
      set0(1'b1, 2'd2, 1'b0, 32'h60, 32'h4433_2211);
      step(); step();
      reset = 1'b0;
      step();
      chk("mr_busy_we", {30'd0, busy, ram_we}, 32'd0);
      chk("mr_noack", {30'd0, ack1, ack0}, 32'd0);
      req0 = 1'b0;
      reset = 1'b1;
      step(); step();
      chk("mr_mem", {mem[16'h63], mem[16'h62], mem[16'h61], mem[16'h60]}, 32'h0000_2211);

      // Priority restored to port 0 after reset
      set0(1'b1, 2'd0, 1'b0, 32'h70, 32'h0000_0077);
      set1(1'b1, 2'd0, 1'b0, 32'h71, 32'h0000_0088);
      wait_ack(a0, a1, cyc);
      chk("mr_prio", {30'd0, a1, a0}, 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      step(); step();

      chk("ack0_count", 32'(n_ack0), 32'd8);
      chk("ack1_count", 32'(n_ack1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
